// File: rtl/clk_div_pkg.sv
// Shared types and default sizing for the carrier/clock divider sequencer.
package clk_div_pkg;

    localparam int unsigned DEF_CNT_W    = 8;
    localparam int unsigned DEF_CYC_W    = 16;
    localparam int unsigned DEF_RST_HALF = 63;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Divider configuration at the default field widths.
    typedef struct packed {
        logic [DEF_CNT_W-1:0] half;
        logic [DEF_CYC_W-1:0] cycles;
    } cfg_t;

endpackage

// File: rtl/clk_div_core.sv
// Half-period counter and toggle flop; registered clock and edge strobes.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] half,
    output logic             clk_out,
    output logic             rise,
    output logic             fall,
    output logic             fall_next
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             clk_q, clk_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             wrap;

    assign wrap = (count_q == half);

    always_comb begin
        count_d = count_q;
        clk_d   = clk_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (clr) begin
            count_d = '0;
            clk_d   = 1'b0;
        end else if (en) begin
            if (wrap) begin
                count_d = '0;
                clk_d   = ~clk_q;
                rise_d  = ~clk_q;
                fall_d  = clk_q;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            clk_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            clk_q   <= clk_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clk_out   = clk_q;
    assign rise      = rise_q;
    assign fall      = fall_q;
    // The next enabled edge will take clk_out high->low.
    assign fall_next = wrap & clk_q;

endmodule

// File: rtl/clk_div_sched.sv
// Divider sequencer: config shadow, IDLE/RUN/DRAIN FSM and burst period counting.
// Optional CLK_DIV_SCHED_PERIOD_CNT_EN exposes the live completed-period count.
module clk_div_sched
    import clk_div_pkg::*;
#(
    parameter int unsigned     CNT_W    = DEF_CNT_W,
    parameter int unsigned     CYC_W    = DEF_CYC_W,
    parameter logic [CNT_W-1:0] RST_HALF = CNT_W'(DEF_RST_HALF)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_half,
    input  logic [CYC_W-1:0] cfg_cycles,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             done,
    output logic             clk_out,
    output logic             edge_rise,
    output logic             edge_fall
`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
    ,
    output logic [CYC_W-1:0] periods_done
`endif
);

    typedef struct packed {
        logic [CNT_W-1:0] half;
        logic [CYC_W-1:0] cycles;
    } shadow_t;

    state_e           state_q, state_d;
    shadow_t          shadow_q, shadow_d;
    logic [CYC_W-1:0] pcnt_q, pcnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             core_en;
    logic             core_clr;
    logic             core_clk;
    logic             core_fall_next;
    logic [CYC_W-1:0] pcnt_sat;
    logic             last_period;

    clk_div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk       (clk_in),
        .rst       (rst_in),
        .en        (core_en),
        .clr       (core_clr),
        .half      (shadow_q.half),
        .clk_out   (core_clk),
        .rise      (edge_rise),
        .fall      (edge_fall),
        .fall_next (core_fall_next)
    );

    assign pcnt_sat    = (pcnt_q == '1) ? pcnt_q : pcnt_q + CYC_W'(1);
    assign last_period = (shadow_q.cycles != '0) && (pcnt_sat == shadow_q.cycles);

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        pcnt_d   = pcnt_q;
        done_d   = 1'b0;
        core_en  = 1'b0;
        core_clr = 1'b0;

        if (cfg_valid && state_q == IDLE) begin
            shadow_d.half   = cfg_half;
            shadow_d.cycles = cfg_cycles;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    core_clr = 1'b1;
                    pcnt_d   = '0;
                end
            end
            RUN: begin
                // A stop during the low phase may cut it short; the high phase never.
                if (stop && !core_clk) begin
                    state_d  = IDLE;
                    core_clr = 1'b1;
                    done_d   = 1'b1;
                end else begin
                    core_en = 1'b1;
                    if (core_fall_next) begin
                        pcnt_d = pcnt_sat;
                        if (last_period || stop) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else if (stop) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                core_en = 1'b1;
                if (core_fall_next) begin
                    pcnt_d  = pcnt_sat;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q         <= IDLE;
            shadow_q.half   <= RST_HALF;
            shadow_q.cycles <= '0;
            pcnt_q          <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            pcnt_q   <= pcnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign cfg_ready = (state_q == IDLE);
    assign busy      = busy_q;
    assign done      = done_q;
    assign clk_out   = core_clk;

`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
    assign periods_done = pcnt_q;
`else
`endif

endmodule

// File: tb/tb_clk_div_sched.sv
// Directed self-checking bench for clk_div_sched with hand-computed expectations.
module tb_clk_div_sched;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  cfg_half;
    logic [15:0] cfg_cycles;
    logic        start;
    logic        stop;
    logic        busy;
    logic        done;
    logic        clk_out;
    logic        edge_rise;
    logic        edge_fall;
`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
    logic [15:0] periods_done;
`endif

    int total = 0;
    int bad   = 0;
    int n_hit;

    clk_div_sched #(
        .CNT_W    (8),
        .CYC_W    (16),
        .RST_HALF (8'd63)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_half   (cfg_half),
        .cfg_cycles (cfg_cycles),
        .start      (start),
        .stop       (stop),
        .busy       (busy),
        .done       (done),
        .clk_out    (clk_out),
        .edge_rise  (edge_rise),
        .edge_fall  (edge_fall)
`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
        ,
        .periods_done (periods_done)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_in     = 1'b1;
        cfg_valid  = 1'b0;
        cfg_half   = '0;
        cfg_cycles = '0;
        start      = 1'b0;
        stop       = 1'b0;
        repeat (3) tick();
        check("rst_clk", clk_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rise", edge_rise, 0);
        check("rst_fall", edge_fall, 0);
        check("rst_ready", cfg_ready, 1);
        rst_in = 1'b0;
        tick();

        // Default divide-by-128, continuous run.
        start = 1'b1; tick(); start = 1'b0;
        check("t1_busy", busy, 1);
        check("t1_clk0", clk_out, 0);
        n_hit = 0;
        repeat (63) begin tick(); n_hit += int'(clk_out) + int'(done); end
        check("t1_low_phase", n_hit, 0);
        tick();
        check("t1_rise_clk", clk_out, 1);
        check("t1_rise_strobe", edge_rise, 1);
        n_hit = 0;
        repeat (63) begin tick(); n_hit += int'(!clk_out) + int'(done); end
        check("t1_high_phase", n_hit, 0);
        tick();
        check("t1_fall_clk", clk_out, 0);
        check("t1_fall_strobe", edge_fall, 1);
        check("t1_no_done", done, 0);
        stop = 1'b1; tick(); stop = 1'b0;
        check("t1_stop_done", done, 1);
        check("t1_stop_busy", busy, 0);
        tick();
        check("t1_done_once", done, 0);

        // half=3 cycles=2 burst: 16 RUN cycles.
        cfg_valid = 1'b1; cfg_half = 8'd3; cfg_cycles = 16'd2;
        check("t2_ready", cfg_ready, 1);
        tick(); cfg_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("t2_clk", clk_out, ((k >= 4 && k < 8) || (k >= 12 && k < 16)) ? 1 : 0);
            check("t2_done", done, (k == 16) ? 1 : 0);
            check("t2_busy", busy, (k < 16) ? 1 : 0);
        end
        check("t2_last_fall", edge_fall, 1);
`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
        check("t2_periods", periods_done, 2);
`endif
        tick();
        check("t2_done_once", done, 0);
        check("t2_clk_idle", clk_out, 0);

        // half=7 continuous; stop 3 cycles after rise drains the high phase.
        cfg_valid = 1'b1; cfg_half = 8'd7; cfg_cycles = 16'd0;
        tick(); cfg_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (11) tick();
        check("t3_high", clk_out, 1);
        stop = 1'b1;
        tick();
        check("t3_drain_busy", busy, 1);
        check("t3_drain_clk", clk_out, 1);
        repeat (3) tick();
        check("t3_still_high", clk_out, 1);
        check("t3_no_done_yet", done, 0);
        tick();
        check("t3_fall", clk_out, 0);
        check("t3_fall_strobe", edge_fall, 1);
        check("t3_done", done, 1);
        check("t3_busy", busy, 0);
        stop = 1'b0;
        tick();
        check("t3_done_once", done, 0);

        // Stop 2 cycles after a fall truncates the low phase.
        start = 1'b1; tick(); start = 1'b0;
        repeat (18) tick();
        check("t4_low", clk_out, 0);
        check("t4_busy", busy, 1);
        stop = 1'b1; tick(); stop = 1'b0;
        check("t4_done", done, 1);
        check("t4_busy_off", busy, 0);
        check("t4_clk", clk_out, 0);
        n_hit = 0;
        repeat (10) begin tick(); n_hit += int'(clk_out) + int'(done) + int'(edge_rise); end
        check("t4_quiet", n_hit, 0);

        // Config offered while busy is refused; next run keeps half=7.
        start = 1'b1; tick(); start = 1'b0;
        tick();
        cfg_valid = 1'b1; cfg_half = 8'd1; cfg_cycles = 16'd1;
        check("t5_ready_busy", cfg_ready, 0);
        tick(); cfg_valid = 1'b0;
        stop = 1'b1; tick(); stop = 1'b0;
        check("t5_stop_done", done, 1);
        start = 1'b1; tick(); start = 1'b0;
        repeat (7) tick();
        check("t5_old_half_low", clk_out, 0);
        tick();
        check("t5_old_half_rise", edge_rise, 1);
        stop = 1'b1; tick(); stop = 1'b0;
        repeat (6) tick();
        check("t5_drain_high", clk_out, 1);
        tick();
        check("t5_drain_done", done, 1);
        check("t5_drain_clk", clk_out, 0);

        // Config and start in the same IDLE cycle: half=1 cycles=1.
        cfg_valid = 1'b1; cfg_half = 8'd1; cfg_cycles = 16'd1; start = 1'b1;
        check("t5_ready_idle", cfg_ready, 1);
        tick(); cfg_valid = 1'b0; start = 1'b0;
        tick();
        check("t5_new_e1", clk_out, 0);
        tick();
        check("t5_new_rise", edge_rise, 1);
        tick();
        check("t5_new_e3", clk_out, 1);
        tick();
        check("t5_new_fall", clk_out, 0);
        check("t5_new_done", done, 1);
        check("t5_new_busy", busy, 0);

        // half=0 divide-by-2, three periods.
        cfg_valid = 1'b1; cfg_half = 8'd0; cfg_cycles = 16'd3; start = 1'b1;
        tick(); cfg_valid = 1'b0; start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("t6_clk", clk_out, k % 2);
            check("t6_rise", edge_rise, k % 2);
            check("t6_fall", edge_fall, (k % 2 == 0) ? 1 : 0);
            check("t6_done", done, (k == 6) ? 1 : 0);
        end

        // Stop on the terminal falling toggle gives a single done.
        cfg_valid = 1'b1; cfg_half = 8'd1; cfg_cycles = 16'd1; start = 1'b1;
        tick(); cfg_valid = 1'b0; start = 1'b0;
        repeat (3) tick();
        check("t7_high", clk_out, 1);
        stop = 1'b1; tick();
        check("t7_done", done, 1);
        check("t7_busy", busy, 0);
        check("t7_clk", clk_out, 0);
        tick(); stop = 1'b0;
        check("t7_done_once", done, 0);

        // Asynchronous reset mid high phase.
        cfg_valid = 1'b1; cfg_half = 8'd7; cfg_cycles = 16'd0; start = 1'b1;
        tick(); cfg_valid = 1'b0; start = 1'b0;
        repeat (10) tick();
        check("t8_pre_high", clk_out, 1);
        rst_in = 1'b1;
        #1;
        check("t8_clk", clk_out, 0);
        check("t8_busy", busy, 0);
        check("t8_done", done, 0);
        check("t8_rise", edge_rise, 0);
        check("t8_fall", edge_fall, 0);
        check("t8_ready", cfg_ready, 1);
        #3 rst_in = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (63) tick();
        check("t8_half63_low", clk_out, 0);
        tick();
        check("t8_half63_rise", edge_rise, 1);
        stop = 1'b1; tick(); stop = 1'b0;
        repeat (62) tick();
        check("t8_drain_high", clk_out, 1);
        tick();
        check("t8_drain_done", done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
